// File: rtl/game_frame_serializer.sv
// Captures encoder frames on the rising edge of the ready level and shifts them out
// MSB-first over a mode-0 SPI link, holding one further frame in a pending buffer.
package game_state_pkg;
   localparam int ROWS = 10;
   localparam int COLS = 20;
   typedef logic [ROWS-1:0][COLS-1:0] game_state_t;
endpackage

module game_frame_serializer #(
   parameter int SCLK_DIV   = 24,
   parameter int GAP_CYCLES = 48
) (
   input  logic                        HSOSC_clk,
   input  logic                        reset_n,
   input  logic                        GAME_new_frame_ready,
   input  game_state_pkg::game_state_t GAME_next_frame,
   output logic                        SPI_sclk,
   output logic                        SPI_mosi,
   output logic                        SPI_cs_n,
   output logic                        TX_busy,
   output logic                        TX_frame_done,
   output logic                        TX_overrun,
   output logic [1:0]                  dbg_state_o
);
   import game_state_pkg::*;

   localparam int FRAME_W = ROWS * COLS;
   localparam int DIV_W   = $clog2(SCLK_DIV + 1);
   localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
   localparam logic [7:0]       LAST_BIT = 8'(FRAME_W - 1);
   // The IDLE cycle before a queued frame starts is part of the cs_n-high gap.
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES >= 2) ? GAP_CYCLES - 2 : 0);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_e;

   state_e               state_q;
   logic                 ready_q;
   logic                 pending_q;
   logic [FRAME_W-1:0]   pending_buf_q;
   logic [FRAME_W-1:0]   shift_reg_q;
   logic [7:0]           bit_cnt_q;
   logic [DIV_W-1:0]     div_cnt_q;
   logic [GAP_W-1:0]     gap_cnt_q;
   logic                 sclk_q;
   logic                 mosi_q;
   logic                 cs_n_q;
   logic                 frame_done_q;
   logic                 overrun_q;

   logic                 edge_d;
   logic                 consume_d;
   logic [FRAME_W-1:0]   frame_flat_d;

   // Flatten so screen[0] bit 19 lands in the MSB and leaves the link first.
   always_comb begin
      frame_flat_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         frame_flat_d[FRAME_W-1-COLS*r -: COLS] = GAME_next_frame[r];
      end
   end

   assign edge_d    = GAME_new_frame_ready & ~ready_q;
   assign consume_d = (state_q == IDLE) & pending_q;

   always_ff @(posedge HSOSC_clk) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         ready_q       <= 1'b0;
         pending_q     <= 1'b0;
         pending_buf_q <= '0;
         shift_reg_q   <= '0;
         bit_cnt_q     <= '0;
         div_cnt_q     <= '0;
         gap_cnt_q     <= '0;
         sclk_q        <= 1'b0;
         mosi_q        <= 1'b0;
         cs_n_q        <= 1'b1;
         frame_done_q  <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         ready_q      <= GAME_new_frame_ready;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;

         if (edge_d) begin
            pending_buf_q <= frame_flat_d;
            pending_q     <= 1'b1;
            overrun_q     <= pending_q & ~consume_d;
         end else if (consume_d) begin
            pending_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (pending_q) begin
                  state_q     <= SHIFT;
                  shift_reg_q <= {pending_buf_q[FRAME_W-2:0], 1'b0};
                  mosi_q      <= pending_buf_q[FRAME_W-1];
                  cs_n_q      <= 1'b0;
                  sclk_q      <= 1'b0;
                  bit_cnt_q   <= '0;
                  div_cnt_q   <= '0;
               end
            end
            SHIFT: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  if (!sclk_q) begin
                     sclk_q <= 1'b1;
                  end else begin
                     sclk_q <= 1'b0;
                     if (bit_cnt_q == LAST_BIT) begin
                        cs_n_q       <= 1'b1;
                        mosi_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        gap_cnt_q    <= '0;
                        state_q      <= GAP;
                     end else begin
                        bit_cnt_q   <= bit_cnt_q + 8'd1;
                        mosi_q      <= shift_reg_q[FRAME_W-1];
                        shift_reg_q <= {shift_reg_q[FRAME_W-2:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + DIV_W'(1);
               end
            end
            GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  state_q <= IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + GAP_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign SPI_sclk      = sclk_q;
   assign SPI_mosi      = mosi_q;
   assign SPI_cs_n      = cs_n_q;
   assign TX_busy       = (state_q != IDLE);
   assign TX_frame_done = frame_done_q;
   assign TX_overrun    = overrun_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_game_frame_serializer.sv
// Directed bench for game_frame_serializer: frames go into an expected queue when
// issued; a negedge monitor reassembles each SPI frame and compares it.
module tb_game_frame_serializer;
   import game_state_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ready = 1'b0;
   game_state_t frame_in = '0;
   logic        sclk, mosi, cs_n, busy, done, ovr;
   logic [1:0]  dbg_state;

   game_frame_serializer #(.SCLK_DIV(2), .GAP_CYCLES(4)) dut (
      .HSOSC_clk            (clk),
      .reset_n              (reset_n),
      .GAME_new_frame_ready (ready),
      .GAME_next_frame      (frame_in),
      .SPI_sclk             (sclk),
      .SPI_mosi             (mosi),
      .SPI_cs_n             (cs_n),
      .TX_busy              (busy),
      .TX_frame_done        (done),
      .TX_overrun           (ovr),
      .dbg_state_o          (dbg_state)
   );

   always #5 clk = ~clk;

   // scoreboard state
   logic [199:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int ovr_cnt = 0, done_cnt = 0, start_cnt = 0, frames_seen = 0;
   int gap_checks = 0;

   task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic game_state_t mk(input logic [199:0] flat);
      game_state_t s;
      for (int r = 0; r < 10; r++) s[r] = flat[199-20*r -: 20];
      return s;
   endfunction

   // monitor
   logic         prev_cs = 1'b1, prev_sclk = 1'b0, in_frame = 1'b0, gap_valid = 1'b0;
   logic [199:0] rx, exp_f;
   int           nrise, low_len, busy_drop, gap_len;

   always @(negedge clk) begin
      if (!reset_n) begin
         in_frame  = 1'b0;
         gap_valid = 1'b0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b0;
      end else begin
         if (ovr) ovr_cnt++;
         if (done) done_cnt++;
         if (prev_cs && !cs_n) begin
            start_cnt++;
            if (gap_checks > 0 && gap_valid) begin
               check("gap_len", gap_len, 4);
               gap_checks--;
            end
            in_frame = 1'b1; rx = '0; nrise = 0; low_len = 0; busy_drop = 0;
         end
         if (!cs_n && in_frame) begin
            low_len++;
            if (!busy) busy_drop++;
            if (sclk && !prev_sclk) begin
               rx = {rx[198:0], mosi};
               nrise++;
            end
         end
         if (!prev_cs && cs_n && in_frame) begin
            in_frame = 1'b0;
            frames_seen++;
            check("done_pulse", done, 1);
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               exp_f = exp_q.pop_front();
               check("frame_data", rx, exp_f);
               check("sclk_rises", nrise, 200);
               check("cs_low_cycles", low_len, 800);
               check("busy_in_frame", busy_drop, 0);
            end
            gap_valid = 1'b1;
            gap_len = 0;
         end
         if (cs_n && gap_valid) gap_len++;
         prev_cs   = cs_n;
         prev_sclk = sclk;
      end
   end

   // driver tasks
   task automatic send_frame(input logic [199:0] f, input bit push);
      if (push) exp_q.push_back(f);
      frame_in = mk(f);
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      check("wait_done_in_budget", n < budget, 1);
   endtask

   task automatic wait_cs_rise(input int budget);
      int n = 0;
      while (cs_n && n < budget) begin @(posedge clk); #1; n++; end
      while (!cs_n && n < budget) begin @(posedge clk); #1; n++; end
      check("cs_rise_in_budget", n < budget, 1);
   endtask

   int ovr0, start0;

   initial begin
      // reset
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cs_n", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_mosi", mosi, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_overrun", ovr, 0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single frame, vertical bar
      send_frame({10{20'hCF4EE}}, 1'b1);
      wait_done(2000);
      check("single_done_count", done_cnt, 1);

      // row order
      send_frame({20'hFFFFF, 180'd0}, 1'b1);
      wait_done(2000);

      // queue during transfer
      ovr0 = ovr_cnt;
      send_frame({10{20'h12345}}, 1'b1);
      repeat (1 + 4*50) @(posedge clk);
      #1;
      gap_checks = 1;
      send_frame({5{20'hF0F0F, 20'h0F0F0}}, 1'b1);
      wait_done(4000);
      check("queue_no_overrun", ovr_cnt - ovr0, 0);
      check("queue_gap_checked", gap_checks, 0);

      // overrun: A, B, C; B is overwritten
      ovr0 = ovr_cnt;
      send_frame({10{20'hA5A5A}}, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      send_frame({10{20'hBBBBB}}, 1'b0);
      repeat (100) @(posedge clk);
      #1;
      send_frame({20'h00001, 20'h00002, 20'h00004, 20'h00008, 20'h00010,
                  20'h00020, 20'h00040, 20'h00080, 20'h00100, 20'h80000}, 1'b1);
      wait_done(4000);
      check("overrun_count", ovr_cnt - ovr0, 1);

      // reset mid-transfer with a frame pending
      send_frame({10{20'h3C3C3}}, 1'b0);
      repeat (4*60) @(posedge clk);
      #1;
      send_frame({10{20'h55555}}, 1'b0);
      repeat (4*60) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_cs_n", cs_n, 1);
      check("midrst_sclk", sclk, 0);
      check("midrst_busy", busy, 0);
      reset_n = 1'b1;
      start0 = start_cnt;
      repeat (1000) @(posedge clk);
      #1;
      check("midrst_no_restart", start_cnt - start0, 0);
      check("midrst_idle", busy, 0);

      // held-high ready: one capture only
      start0 = start_cnt;
      exp_q.push_back({10{20'h9E3C1}});
      frame_in = mk({10{20'h9E3C1}});
      ready = 1'b1;
      repeat (1000) @(posedge clk);
      #1;
      ready = 1'b0;
      wait_done(2000);
      repeat (20) @(posedge clk);
      #1;
      check("held_one_capture", start_cnt - start0, 1);

      // edge coincident with the IDLE consume
      ovr0 = ovr_cnt;
      send_frame({10{20'h11111}}, 1'b1);
      repeat (100) @(posedge clk);
      #1;
      gap_checks = 2;
      send_frame({10{20'h22222}}, 1'b1);
      wait_cs_rise(2000);
      repeat (3) @(posedge clk);
      #1;
      send_frame({10{20'h44444}}, 1'b1);
      wait_done(4000);
      check("simul_no_overrun", ovr_cnt - ovr0, 0);
      check("simul_gaps_checked", gap_checks, 0);

      repeat (10) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      check("done_matches_frames", done_cnt, frames_seen);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
